// File: rtl/ex_unit_pkg.sv
// Shared definitions for the OpenMIPS execute stage:
// opcodes, result classes, widths and multiplier states.
package openmips_defs;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_MOVZ  = 8'h0A;
  localparam logic [7:0] OP_MOVN  = 8'h0B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_MUL   = 3'b100;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_BUSY,
    MS_DONE
  } mul_state_t;

  // 0x80000000 negates to itself; callers treat the result as unsigned
  function automatic logic [31:0] mag32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_unit_mul_seq.sv
// Iterative 32-step shift-add multiplier with
// IDLE/BUSY/DONE control and signed correction.
module mul_seq
  import openmips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  mul_state_t  state;
  mul_state_t  state_nx;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic        neg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MS_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      MS_IDLE: begin
        if (start) begin
          busy     = 1'b1;
          state_nx = MS_BUSY;
        end
      end
      MS_BUSY: begin
        busy = 1'b1;
        if (cnt == 5'd31) begin
          state_nx = MS_DONE;
        end
      end
      MS_DONE: begin
        done     = 1'b1;
        state_nx = MS_IDLE;
      end
      default: state_nx = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else if (state == MS_IDLE && start) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {32'd0, mag32(a, signed_op)};
      mplier <= mag32(b, signed_op);
      neg    <= signed_op & (a[31] ^ b[31]);
    end else if (state == MS_BUSY) begin
      acc    <= acc + (mplier[0] ? mcand : 64'd0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
    end
  end

  assign product = neg ? (~acc + 64'd1) : acc;

endmodule

// File: rtl/ex_unit.sv
// OpenMIPS execute stage: result mux, HI/LO,
// EX forwarding and the EX/MEM register.
module ex_unit
  import openmips_defs::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            alu_op,
  input  logic [2:0]            alu_sel,
  input  logic [DATA_W-1:0]     src_data1,
  input  logic [DATA_W-1:0]     src_data2,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic                  wr_en,
  output logic                  ex_rewrite_en,
  output logic [REG_ADDR_W-1:0] ex_rewrite_addr,
  output logic [DATA_W-1:0]     ex_rewrite_data,
  output logic                  mem_wr_en,
  output logic [REG_ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0]     mem_wr_data,
  output logic                  stall_req,
  output logic [DATA_W-1:0]     hi_out,
  output logic [DATA_W-1:0]     lo_out
);

  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] result;
  logic [4:0]        sh;
  logic              mul_busy;
  logic              mul_done;
  logic [63:0]       product;

  assign sh = src_data1[4:0];

  mul_seq u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (alu_sel == SEL_MUL),
    .signed_op (alu_op == OP_MULT),
    .a         (src_data1),
    .b         (src_data2),
    .busy      (mul_busy),
    .done      (mul_done),
    .product   (product)
  );

  always_comb begin
    result = '0;
    unique case (1'b1)
      (alu_sel == SEL_LOGIC): begin
        case (alu_op)
          OP_AND:  result = src_data1 & src_data2;
          OP_OR:   result = src_data1 | src_data2;
          OP_XOR:  result = src_data1 ^ src_data2;
          OP_NOR:  result = ~(src_data1 | src_data2);
          default: result = '0;
        endcase
      end
      (alu_sel == SEL_SHIFT): begin
        case (alu_op)
          OP_SLL:  result = src_data2 << sh;
          OP_SRL:  result = src_data2 >> sh;
          OP_SRA:  result = $signed(src_data2) >>> sh;
          default: result = '0;
        endcase
      end
      (alu_sel == SEL_MOVE): begin
        case (alu_op)
          OP_MOVZ: result = src_data1;
          OP_MOVN: result = src_data1;
          OP_MFHI: result = hi;
          OP_MFLO: result = lo;
          default: result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  assign stall_req       = mul_busy;
  assign ex_rewrite_en   = wr_en & ~stall_req;
  assign ex_rewrite_addr = wr_addr;
  assign ex_rewrite_data = result;

  // MTHI/MTLO never coincide with DONE since upstream is held
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (mul_done) begin
      hi <= product[63:32];
      lo <= product[31:0];
    end else if (alu_sel == SEL_MOVE) begin
      if (alu_op == OP_MTHI) hi <= src_data1;
      if (alu_op == OP_MTLO) lo <= src_data1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else if (stall_req || mul_done) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_en   <= wr_en;
      mem_wr_addr <= wr_addr;
      mem_wr_data <= result;
    end
  end

  assign hi_out = hi;
  assign lo_out = lo;

endmodule

// File: doc/ex_unit.md
# ex_unit

Execute stage of the OpenMIPS five-stage pipeline, sitting between the ID/EX register and the MEM stage. It consumes the decoded operation (`alu_op`, `alu_sel`, `src_data1`, `src_data2`, `wr_addr`, `wr_en`) and computes logic, shift and move results. It owns the HI/LO register pair and runs an iterative 32-cycle MULT/MULTU unit that stalls upstream. It drives the EX forwarding path (`ex_rewrite_*`) back into decode and registers the result into EX/MEM.

## Interface
- `DATA_W`, 32, datapath width (only 32 supported)
- `REG_ADDR_W`, 5, GPR address width
- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets the block
- `alu_op` in 8: operation code (shared package constants)
- `alu_sel` in 3: result class: 001 logic, 010 shift, 011 move, 100 multiply
- `src_data1` in 32: operand 1 (rs, or immediate/shamt)
- `src_data2` in 32: operand 2 (rt, or immediate)
- `wr_addr` in 5: destination GPR
- `wr_en` in 1: GPR write request from decode
- `ex_rewrite_en` / `ex_rewrite_addr` / `ex_rewrite_data` out 1/5/32: combinational forward of the current result
- `mem_wr_en` / `mem_wr_addr` / `mem_wr_data` out 1/5/32: registered EX/MEM outputs
- `stall_req` out 1: upstream holds the ID/EX register while high
- `hi_out`, `lo_out` out 32: current HI/LO, for debug and bench

## Operation
- **Logic** (sel 001): AND 0x24, OR 0x25, XOR 0x26, NOR 0x27 on `src_data1`, `src_data2`.
- **Shift** (sel 010): value is `src_data2`, amount is `src_data1[4:0]`.
  - SLL/SLLV 0x7C: logical left.
  - SRL/SRLV 0x02: logical right.
  - SRA/SRAV 0x03: arithmetic right.
- **Move** (sel 011):
  - MOVZ 0x0A and MOVN 0x0B: result = `src_data1`; `wr_en` is taken as supplied by decode.
  - MFHI 0x10: result = HI. MFLO 0x12: result = LO.
  - MTHI 0x11: HI ← `src_data1`. MTLO 0x13: LO ← `src_data1`. Both update at the clock edge.
- **Multiply** (sel 100): MULT 0x18 (signed), MULTU 0x19 (unsigned). Result goes to {HI, LO}; no GPR write.
- Unknown op or sel: result = 0; `wr_en` still passes through.
- **Forward path:** `ex_rewrite_en` = `wr_en` & ~`stall_req`; `ex_rewrite_addr` = `wr_addr`; `ex_rewrite_data` = result.
- **Multiplier FSM:**
  - IDLE: when sel=100 is present, `stall_req`=1 combinationally. At the edge, latch operand magnitudes (absolute values for MULT) and the result sign, clear the accumulator, set cnt=0, go to BUSY.
  - BUSY: one shift-add step per cycle, `stall_req`=1. When cnt==31 at an edge, go to DONE.
  - DONE: `stall_req`=0. At the edge, write {HI, LO} with the sign-corrected 64-bit product and go to IDLE. The held MULT is consumed at that edge and must not restart.
- **MULT sign fix:** negate the 64-bit product when the operand signs differ. Negating 0x80000000 yields 0x80000000, which must be treated as an unsigned magnitude.

## Timing
- **Reset values:** all outputs 0; HI=LO=0; FSM=IDLE; cnt=0.
- **Non-multiply ops:** `ex_rewrite_*` valid in the same cycle; `mem_wr_*` valid one cycle later. Throughput is 1 per cycle.
- **MULT presented at cycle T:** `stall_req` is high in T..T+32 and low in T+33 (DONE). HI/LO hold the new value from T+34, so a following MFHI reads it.
- **EX/MEM during a stall:** while `stall_req`=1, load a bubble (`mem_wr_en`=0, addr=0, data=0). The DONE cycle also loads a bubble.
- **HI/LO writers:** MTHI/MTLO cannot coincide with DONE, because upstream is stalled.
- **Reset mid-operation:** reset during BUSY or DONE returns the FSM to IDLE next cycle with `stall_req`=0, HI/LO=0 and no partial write.
- Input changes while `stall_req`=1 violate the protocol; the bench flags them.

## Structure
- Package `openmips_defs`: `alu_op` constants (AND..MULTU), `alu_sel` class constants, `DATA_W`, `REG_ADDR_W`.
- Sub-module `mul_seq`: sign handling, shift-add datapath, cnt, and the IDLE/BUSY/DONE FSM. Ports: start, signed_op, a, b, busy, done, product[63:0].
- `ex_unit` contains the result mux, HI/LO registers, EX/MEM register and forward logic.

## Test plan
- OR 0x25, src1=0x0000FF00, src2=0x00F0F0F0, wr_addr=3, wr_en=1 → `ex_rewrite_data`=0x00F0FFF0 in the same cycle; `mem_wr_*`=(1, 3, 0x00F0FFF0) next cycle.
- SRA, src1=4, src2=0x80000000 → 0xF8000000. SLL, src1=8, src2=0x000000FF → 0x0000FF00. SRL, src1=31, src2=0x80000000 → 1.
- MTHI src1=0x12345678, then MFHI wr_addr=5 → `mem_wr_data`=0x12345678; `lo_out` unchanged.
- MULT 0xFFFFFFFE × 3 → `stall_req` high exactly 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- Reset asserted (`reset`=0) in BUSY cycle 10 → next cycle `stall_req`=0, HI=LO=0, `mem_wr_en`=0. A new MULT after release completes normally.
